// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR: FSM state encoding, accumulator
// sizing and the power-on coefficient rule (identity filter).
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } fir_state_t;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Tap 0 resets to unity and every other tap to zero, so out-of-reset the filter passes samples through.
  function automatic int reset_coef(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/fir_out_scale.sv
// Combinational accumulator-to-output scaler. Define FIR_ROUND_SAT_EN for
// round-half-up plus saturation; otherwise the result is truncated and wraps.
module fir_out_scale #(
  parameter int ACC_W = 35,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] result
);

  // One guard bit above the wider of the accumulator and the shifted output window.
  localparam int EXT_W = ((ACC_W > OUT_W + SHIFT) ? ACC_W : OUT_W + SHIFT) + 1;

  logic signed [EXT_W-1:0] ext;

  assign ext = EXT_W'(acc);

`ifdef FIR_ROUND_SAT_EN
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [EXT_W-1:0] RND = EXT_W'(SHIFT > 0) <<< RND_SH;

  logic signed [EXT_W-1:0] shifted;
  logic [EXT_W-OUT_W:0]    top_bits;

  assign shifted  = (ext + RND) >>> SHIFT;
  assign top_bits = shifted[EXT_W-1:OUT_W-1];

  // The value fits when every bit above the output sign bit repeats it.
  always_comb begin
    if (&top_bits || ~|top_bits) begin
      result = shifted[OUT_W-1:0];
    end else if (shifted[EXT_W-1]) begin
      result = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      result = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign result = OUT_W'(ext >>> SHIFT);
`endif

endmodule

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one signed MAC per clock over a TAPS-deep delay line,
// with a runtime coefficient port. Output scaling honours FIR_ROUND_SAT_EN.
module fir_mac_serial
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  sample_in,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   filter_out
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  fir_state_t state, state_nxt;

  logic [ADDR_W-1:0]        idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  scaled;
  logic                     accept;
  logic                     last_tap;
  logic                     addr_ok;

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign last_tap = (idx == ADDR_W'(TAPS - 1));
  assign prod     = PROD_W'(x[idx]) * PROD_W'(c[idx]);

  // Out-of-range addresses only exist when TAPS is not a power of two.
  generate
    if (TAPS == (1 << ADDR_W)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (32'(coef_addr) < TAPS);
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      filter_out <= '0;
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x[0] <= sample_in;
            for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + ADDR_W'(1);
        end
        DONE: begin
          filter_out <= scaled;
          out_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Writes land at the clock edge, so a MAC reading the same tap that cycle still sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) c[k] <= COEF_W'(reset_coef(k));
    end else if (coef_we && addr_ok) begin
      c[coef_addr] <= coef_data;
    end
  end

  fir_out_scale #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_scale (
    .acc    (acc),
    .result (scaled)
  );

endmodule

// File: tb/tb_fir_mac_serial.sv
// Directed bench for fir_mac_serial: a default 8-tap instance and a 4-tap,
// 16-bit-output, SHIFT=2 instance; expectations follow FIR_ROUND_SAT_EN.
module tb_fir_mac_serial;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  logic               a_in_valid, a_in_ready, a_coef_we, a_out_valid;
  logic signed [15:0] a_sample, a_coef_data;
  logic [2:0]         a_coef_addr;
  logic signed [31:0] a_filter_out;

  logic               b_in_valid, b_in_ready, b_coef_we, b_out_valid;
  logic signed [15:0] b_sample, b_coef_data;
  logic [1:0]         b_coef_addr;
  logic signed [15:0] b_filter_out;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int mc[8];
  int hist[8];

`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [15:0] E_R6  = 16'sd2;
  localparam logic signed [15:0] E_R7  = 16'sd2;
  localparam logic signed [15:0] E_RM6 = -16'sd1;
  localparam logic signed [15:0] E_SP  = 16'sh7FFF;
  localparam logic signed [15:0] E_SN  = 16'sh8000;
`else
  localparam logic signed [15:0] E_R6  = 16'sd1;
  localparam logic signed [15:0] E_R7  = 16'sd1;
  localparam logic signed [15:0] E_RM6 = -16'sd2;
  localparam logic signed [15:0] E_SP  = 16'shFFFE;
  localparam logic signed [15:0] E_SN  = 16'sh0000;
`endif

  fir_mac_serial u_a (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .sample_in  (a_sample),
    .coef_we    (a_coef_we),
    .coef_addr  (a_coef_addr),
    .coef_data  (a_coef_data),
    .out_valid  (a_out_valid),
    .filter_out (a_filter_out)
  );

  fir_mac_serial #(.TAPS(4), .OUT_W(16), .SHIFT(2)) u_b (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .sample_in  (b_sample),
    .coef_we    (b_coef_we),
    .coef_addr  (b_coef_addr),
    .coef_data  (b_coef_data),
    .out_valid  (b_out_valid),
    .filter_out (b_filter_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input logic signed [31:0] obs, input logic signed [31:0] exp,
                             input string tag);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int modelPush(input int s);
    int sum;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    sum = 0;
    for (int k = 0; k < 8; k++) sum += mc[k] * hist[k];
    return sum;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 8; k++) begin
      hist[k] = 0;
      mc[k]   = (k == 0) ? 1 : 0;
    end
  endtask

  task automatic writeCoefA(input int addr, input int val);
    a_coef_addr = 3'(addr);
    a_coef_data = 16'(val);
    a_coef_we   = 1'b1;
    @(negedge clk);
    a_coef_we   = 1'b0;
    mc[addr]    = val;
  endtask

  task automatic writeCoefB(input int addr, input int val);
    b_coef_addr = 2'(addr);
    b_coef_data = 16'(val);
    b_coef_we   = 1'b1;
    @(negedge clk);
    b_coef_we   = 1'b0;
  endtask

  // Drives one sample into the 8-tap instance and checks timing, handshake and result.
  task automatic applyStimulusA(input logic signed [15:0] s, input logic signed [31:0] exp,
                                input string tag);
    int  n;
    int  lat;
    int  unused_model;
    bit  rdy_err;
    n = 0;
    while (!a_in_ready && n < 40) begin @(negedge clk); n++; end
    checkOutput(32'(a_in_ready), 32'sd1, {tag, "_ready"});
    a_sample     = s;
    a_in_valid   = 1'b1;
    unused_model = modelPush(int'(s));
    @(negedge clk);
    a_in_valid = 1'b0;
    lat        = 0;
    rdy_err    = 1'b0;
    while (!a_out_valid && lat < 30) begin
      if (a_in_ready) rdy_err = 1'b1;
      @(negedge clk);
      lat++;
    end
    checkOutput(lat, 32'sd9, {tag, "_latency"});
    checkOutput(32'(rdy_err), 32'sd0, {tag, "_ready_low"});
    checkOutput(32'(a_in_ready), 32'sd1, {tag, "_ready_with_valid"});
    checkOutput(a_filter_out, exp, {tag, "_value"});
    @(negedge clk);
    checkOutput(32'(a_out_valid), 32'sd0, {tag, "_pulse"});
  endtask

  task automatic applyStimulusB(input logic signed [15:0] s, input logic signed [15:0] exp,
                                input string tag);
    int n;
    int lat;
    n = 0;
    while (!b_in_ready && n < 40) begin @(negedge clk); n++; end
    b_sample   = s;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat        = 0;
    while (!b_out_valid && lat < 30) begin @(negedge clk); lat++; end
    checkOutput(lat, 32'sd5, {tag, "_latency"});
    checkOutput(b_filter_out, exp, {tag, "_value"});
  endtask

  initial begin
    logic signed [15:0] vals[5];
    int n;
    int acc_edge;
    int prev_edge;
    int exp_m;
    bit saw_valid;

    vals = '{16'sd100, -16'sd50, 16'sd7, 16'sd1000, -16'sd1};
    a_in_valid = 1'b0; a_sample = '0; a_coef_we = 1'b0; a_coef_addr = '0; a_coef_data = '0;
    b_in_valid = 1'b0; b_sample = '0; b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;
    modelReset();

    // Reset values.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput(32'(a_in_ready), 32'sd0, "reset_ready_a");
    checkOutput(32'(b_in_ready), 32'sd0, "reset_ready_b");
    reset = 1'b0;
    @(negedge clk);
    checkOutput(32'(a_in_ready), 32'sd1, "idle_ready");
    checkOutput(32'(a_out_valid), 32'sd0, "idle_out_valid");
    checkOutput(a_filter_out, 32'sd0, "idle_filter_out");

    // Impulse through identity coefficients.
    applyStimulusA(16'sd256, 32'sd256, "impulse");
    applyStimulusA(16'sd0, 32'sd0, "zero_after");

    // Continuous in_valid against the reference model.
    writeCoefA(0, 3);
    writeCoefA(1, -1);
    writeCoefA(7, 2);
    a_in_valid = 1'b1;
    a_sample   = vals[0];
    prev_edge  = 0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!a_in_ready && n < 40) begin @(negedge clk); n++; end
      checkOutput(32'(a_in_ready), 32'sd1, "cont_ready");
      acc_edge = cyc + 1;
      if (i > 0) checkOutput(acc_edge - prev_edge, 32'sd10, "cont_spacing");
      prev_edge = acc_edge;
      exp_m = modelPush(int'(vals[i]));
      @(negedge clk);
      if (i < 4) a_sample = vals[i+1];
      n = 0;
      while (!a_out_valid && n < 40) begin @(negedge clk); n++; end
      checkOutput(cyc - acc_edge, 32'sd9, "cont_latency");
      checkOutput(a_filter_out, exp_m, "cont_value");
    end
    a_in_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a MAC run.
    n = 0;
    while (!a_in_ready && n < 40) begin @(negedge clk); n++; end
    a_sample   = 16'sd1000;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput(32'(a_in_ready), 32'sd0, "midmac_reset_ready");
    reset = 1'b0;
    modelReset();
    saw_valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (a_out_valid) saw_valid = 1'b1;
    end
    checkOutput(32'(saw_valid), 32'sd0, "midmac_no_valid");
    checkOutput(a_filter_out, 32'sd0, "midmac_filter_out");
    applyStimulusA(16'sd5, 32'sd5, "post_reset_impulse");

    // 4-tap instance: coefficient writes, impulse response scaled by 4.
    writeCoefB(0, 1);
    writeCoefB(1, 2);
    writeCoefB(2, 3);
    writeCoefB(3, 4);
    applyStimulusB(16'sd256, 16'sd64, "b_imp0");
    applyStimulusB(16'sd0, 16'sd128, "b_imp1");
    applyStimulusB(16'sd0, 16'sd192, "b_imp2");
    applyStimulusB(16'sd0, 16'sd256, "b_imp3");
    applyStimulusB(16'sd0, 16'sd0, "b_imp4");

    // Rounding with SHIFT=2.
    writeCoefB(1, 0);
    writeCoefB(2, 0);
    writeCoefB(3, 0);
    applyStimulusB(16'sd6, E_R6, "b_round_6");
    applyStimulusB(16'sd7, E_R7, "b_round_7");
    applyStimulusB(-16'sd6, E_RM6, "b_round_m6");

    // Saturation versus wrap: gain 8 then >>2 overflows 16 bits.
    writeCoefB(0, 8);
    applyStimulusB(16'sh7FFF, E_SP, "b_sat_pos");
    applyStimulusB(16'sh8000, E_SN, "b_sat_neg");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
